// File: rtl/fbrc_sampler.sv
`default_nettype none
// ============================================================================
//  Module   : fbrc_sampler
//  Purpose  : Samples the glitchy, clk-asynchronous output of a ripple
//             counter. The raw count passes through a two-flop synchroniser
//             and a stability filter. Only settled values are accepted.
//             Each accepted value is extended with a wrap-epoch counter and
//             presented on a single valid/ready output register.
//  Ports    :
//    clk        in   1      system clock, rising edge
//    reset      in   1      asynchronous reset, active low
//    cnt_in     in   CNT_W  raw ripple-counter value (asynchronous to clk)
//    clr        in   1      synchronous clear, active high
//    out_ready  in   1      consumer ready
//    out_valid  out  1      out_count holds an unconsumed value
//    out_count  out  EXT_W  {epoch, accepted count}
//    wrap       out  1      one-cycle pulse on an acceptance that wrapped
//    ovf        out  1      sticky: epoch rolled over past all-ones
//    lost       out  1      sticky: an unconsumed value was overwritten
//  Revision : 1.0 - initial release
// ============================================================================
module fbrc_sampler #(
  parameter int CNT_W    = 4,
  parameter int EXT_W    = 8,
  parameter int STABLE_N = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             clr,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [EXT_W-1:0] out_count,
  output logic             wrap,
  output logic             ovf,
  output logic             lost
);

  localparam int c_ep_w = EXT_W - CNT_W;
  localparam int c_st_w = $clog2(STABLE_N + 1);

  localparam logic [c_st_w-1:0] c_stab_max  = c_st_w'(STABLE_N);
  localparam logic [c_st_w-1:0] c_stab_last = c_st_w'(STABLE_N - 1);

  localparam logic [0:0] c_st_init  = 1'b0;
  localparam logic [0:0] c_st_track = 1'b1;

  // --------------------------------------------------------------------------
  // Synchroniser and sample history
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] sync1_q;
  logic [CNT_W-1:0] sync2_q;
  logic [CNT_W-1:0] prev_q;
  // fill_q marks which stages of sync1 -> sync2 -> prev hold real samples.
  // The zeros left in the chain by reset are not samples of the counter, so
  // they must never be able to look like a settled value of 0.
  logic [2:0]       fill_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      fill_q  <= '0;
    end else begin
      sync1_q <= cnt_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fill_q  <= {fill_q[1:0], 1'b1};
    end
  end

  // --------------------------------------------------------------------------
  // Stability filter
  // --------------------------------------------------------------------------
  logic [c_st_w-1:0] stab_q;
  logic [c_st_w-1:0] stab_d;
  logic              w_same;
  logic              w_settled;

  assign w_same    = fill_q[2] && (sync2_q == prev_q);
  // Fires once per run of equal samples; stab then saturates past the
  // trigger point so a long steady value is not reported again.
  assign w_settled = w_same && (stab_q == c_stab_last);

  always_comb begin
    stab_d = stab_q;
    if (clr || !w_same) begin
      stab_d = '0;
    end else if (stab_q != c_stab_max) begin
      stab_d = stab_q + c_st_w'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stab_q <= '0;
    end else begin
      stab_q <= stab_d;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM: INIT waits for a baseline, TRACK follows the counter
  // --------------------------------------------------------------------------
  logic [0:0] state_q;
  logic [0:0] state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= c_st_init;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = c_st_init;
    end else if (w_settled && (state_q == c_st_init)) begin
      state_d = c_st_track;
    end
  end

  // --------------------------------------------------------------------------
  // Acceptance, epoch extension and output register
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]  acc_q;
  logic [CNT_W-1:0]  acc_d;
  logic [c_ep_w-1:0] epoch_q;
  logic [c_ep_w-1:0] epoch_d;
  logic [c_ep_w-1:0] w_epoch_inc;
  logic              out_valid_q;
  logic              out_valid_d;
  logic [EXT_W-1:0]  out_count_q;
  logic [EXT_W-1:0]  out_count_d;
  logic              wrap_q;
  logic              wrap_d;
  logic              ovf_q;
  logic              ovf_d;
  logic              lost_q;
  logic              lost_d;
  logic              w_new;
  logic              w_wrap;

  // In INIT any settled value is the baseline; in TRACK only a change is news.
  assign w_new  = w_settled && ((state_q == c_st_init) || (sync2_q != acc_q));
  // A decrease means the counter passed through zero at least once. Skipped
  // intermediate values still count as a single wrap.
  assign w_wrap = w_settled && (state_q == c_st_track) && (sync2_q < acc_q);

  assign w_epoch_inc = epoch_q + c_ep_w'(1);

  always_comb begin
    acc_d       = acc_q;
    epoch_d     = epoch_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    wrap_d      = 1'b0;
    ovf_d       = ovf_q;
    lost_d      = lost_q;
    if (clr) begin
      acc_d       = '0;
      epoch_d     = '0;
      out_valid_d = 1'b0;
      out_count_d = '0;
      ovf_d       = 1'b0;
      lost_d      = 1'b0;
    end else if (w_new) begin
      acc_d       = sync2_q;
      epoch_d     = w_wrap ? w_epoch_inc : epoch_q;
      wrap_d      = w_wrap;
      ovf_d       = ovf_q | (w_wrap & (&epoch_q));
      // Overwriting a value the consumer has not taken loses it; a transfer
      // in the same cycle frees the register, so nothing is lost then.
      lost_d      = lost_q | (out_valid_q & ~out_ready);
      out_count_d = {(w_wrap ? w_epoch_inc : epoch_q), sync2_q};
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      epoch_q     <= '0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      wrap_q      <= 1'b0;
      ovf_q       <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      epoch_q     <= epoch_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      wrap_q      <= wrap_d;
      ovf_q       <= ovf_d;
      lost_q      <= lost_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign wrap      = wrap_q;
  assign ovf       = ovf_q;
  assign lost      = lost_q;

endmodule
`default_nettype wire

// File: doc/fbrc_sampler.md
Name: fbrc_sampler

Overview:
- Downstream consumer of the 4-bit asynchronous ripple counter. Its count output glitches during ripple and is asynchronous to the system clock.
- Synchronises the raw count and filters ripple transients, then accepts only settled values.
- Extends each accepted count to EXT_W bits using a wrap-epoch counter.
- Presents the result on a valid/ready output register with sticky overflow and data-loss flags.

Parameters:
CNT_W, 4, width of raw ripple-counter input
EXT_W, 8, width of extended output count; epoch width = EXT_W-CNT_W (must be >=1)
STABLE_N, 2, consecutive equal synchronised samples required to accept a value (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
cnt_in  input  CNT_W  raw ripple-counter output, asynchronous to clk
clr  input  1  synchronous clear, active-high
out_ready  input  1  consumer ready
out_valid  output  1  out_count holds an unconsumed value
out_count  output  EXT_W  {epoch, accepted count}
wrap  output  1  one-cycle pulse on the acceptance that detected a wrap
ovf  output  1  sticky: epoch wrapped past its maximum
lost  output  1  sticky: an unconsumed output value was overwritten

Behaviour:
- Reset (reset=0, asynchronous): all registers are 0, state=INIT. Outputs: out_valid=0, out_count=0, wrap=0, ovf=0, lost=0.
- Synchroniser: two-flop chain sync1->sync2 on cnt_in.
- Stability filter:
  - prev captures sync2 every cycle.
  - stab counter resets to 0 when sync2!=prev and increments (saturating at STABLE_N) when sync2==prev.
  - A sample is "settled" when stab==STABLE_N-1 and sync2==prev.
- Latency: a cnt_in value held constant from edge k is accepted and visible on out_count after edge k+STABLE_N+2 (4 edges at default).
- Any value held for fewer than STABLE_N+1 synchronised cycles is never accepted.
- State INIT (no baseline yet):
  - The first settled value becomes acc.
  - Load out_count={0,value}, out_valid=1, no wrap check. Go to TRACK.
- State TRACK:
  - A settled value equal to acc is ignored; there is no re-emit after a filtered transient.
  - A settled value different from acc is accepted. If value<acc (unsigned), it is a wrap: epoch+=1 and wrap=1 for that single cycle.
  - If epoch==all-ones at a wrap, epoch becomes 0 and ovf is set (sticky).
  - acc takes the value; out_count={epoch_new,value}.
  - Any decrease counts as exactly one wrap, even if intermediate values were skipped.
- Output handshake (single register):
  - Transfer occurs on out_valid&&out_ready. Without a new acceptance that cycle, out_valid drops to 0 after the edge.
  - Acceptance with out_valid=0, or with out_valid&&out_ready in the same cycle: load the new value, out_valid=1, lost unchanged.
  - Acceptance with out_valid&&!out_ready: overwrite out_count, keep out_valid=1, set lost (sticky).
  - out_count is held stable while out_valid&&!out_ready, except for the overwrite case above.
- clr=1 (synchronous, higher priority than acceptance that cycle):
  - Clears epoch, acc, stab, out_valid, out_count, wrap, ovf and lost, and sets state=INIT.
  - Synchroniser flops keep running.
- Reset mid-operation: asserting reset immediately forces the reset values, including dropping out_valid without a transfer. After release the block restarts in INIT; the first settled value becomes the new baseline with epoch 0.
- No combinational path from cnt_in to any output. All outputs are registered.

Test Plan:
- Reset/baseline: reset=0 for 2 cycles, then 1; cnt_in=4'h3 steady, out_ready=1 -> out_valid rises 4 edges after first sample, out_count=8'h03, wrap=0.
- Sequence and wrap:
  - Step cnt_in 3->9->F->2, each held 6 cycles, out_ready=1 -> out_count 8'h03, 8'h09, 8'h0F, 8'h12.
  - wrap pulses exactly one cycle with 8'h12.
- Glitch filter: from 8'h12 with cnt_in=2, drive cnt_in=6 for 1 clk cycle then back to 2 -> no new out_valid, out_count stays 8'h12.
- Overflow: 16 wraps from epoch 0 -> out_count epoch returns to 0 on the 16th wrap, ovf=1 and remains 1 until clr.
- Backpressure:
  - out_ready=0 while cnt_in goes 1->5 (held 6 cycles) -> out_count 8'h?1 held, then overwritten by 8'h?5, lost=1.
  - Then assert out_ready=1 and acceptance in the same cycle as a transfer -> lost stays 1, out_valid stays 1.
- clr and reset mid-run:
  - clr=1 for 1 cycle at epoch 3 -> ovf=0, lost=0, out_valid=0; the next settled cnt_in=A gives out_count=8'h0A with no wrap.
  - reset pulse mid-stream -> immediate zero outputs, same INIT behaviour after release.
